mux4_rr_arbiter: RTL and testbench

// - Shares one WIDTH-bit output channel among 4 requesters using round-robin arbitration.
// - Drives the 2-bit select of the 4:1 nibble mux and registers the selected word into a

---
 rtl/mux4_rr_arbiter.sv | 93 +++++++++
 tb/tb_mux4_rr_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter with optional burst lock, driving a 4:1 word mux
// into a single-entry valid/ready output register.
module mux4_rr_arbiter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [3:0]       lock,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             out_ready,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src
);

    localparam int unsigned CntW = $clog2(LOCK_MAX) + 1;
    localparam logic [CntW-1:0] CntLim = CntW'(LOCK_MAX - 1);

    typedef enum logic {StIdle, StFull} state_e;

    state_e           state;
    logic [1:0]       ptr;
    logic [CntW-1:0]  lock_cnt;
    logic             owned;
    logic             lock_hit;
    logic             cap;
    logic [1:0]       winner;
    logic [1:0]       cand;
    logic             found;
    logic [WIDTH-1:0] win_data;

    // owned: at least one capture since reset, so ptr really names the last winner
    assign lock_hit = owned && req[ptr] && lock[ptr] && (lock_cnt < CntLim);

    always_comb begin
        winner = ptr;
        cand   = ptr;
        found  = 1'b0;
        if (!lock_hit) begin
            for (int k = 1; k <= 4; k++) begin
                cand = ptr + k[1:0];
                if (!found && req[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_data = d0;
        unique case (winner)
            2'd0: win_data = d0;
            2'd1: win_data = d1;
            2'd2: win_data = d2;
            2'd3: win_data = d3;
            default: win_data = d0;
        endcase
    end

    assign cap       = !reset && (|req) && (state == StIdle || out_ready);
    assign grant     = cap ? (4'b0001 << winner) : 4'b0000;
    assign sel       = winner;
    assign out_valid = (state == StFull);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            out_data <= '0;
            out_src  <= 2'd0;
            ptr      <= 2'd3;
            lock_cnt <= '0;
            owned    <= 1'b0;
        end else if (cap) begin
            state    <= StFull;
            out_data <= win_data;
            out_src  <= winner;
            ptr      <= winner;
            owned    <= 1'b1;
            lock_cnt <= lock_hit ? lock_cnt + CntW'(1) : '0;
        end else if (state == StFull && out_ready) begin
            state <= StIdle;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench: grants checked per cycle, output words checked by a scoreboard monitor.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req, lock, d0, d1, d2, d3;
    logic       out_ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_src;

    int checks = 0;
    int errors = 0;
    logic [5:0] sb[$];

    mux4_rr_arbiter #(.WIDTH(4), .LOCK_MAX(4)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .out_ready(out_ready),
        .grant(grant), .sel(sel), .out_valid(out_valid),
        .out_data(out_data), .out_src(out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] dsel(input logic [1:0] i);
        case (i)
            2'd0: return d0;
            2'd1: return d1;
            2'd2: return d2;
            default: return d3;
        endcase
    endfunction

    // One cycle: drive inputs, check grant/sel mid-cycle, log the expected captured word.
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rdy,
                        input logic [3:0] eg);
        logic [1:0] idx;
        req = r; lock = l; out_ready = rdy;
        @(negedge clk);
        chk("grant", int'(grant), int'(eg));
        if (eg != 4'b0000) begin
            idx = eg[0] ? 2'd0 : eg[1] ? 2'd1 : eg[2] ? 2'd2 : 2'd3;
            chk("sel", int'(sel), int'(idx));
            sb.push_back({idx, dsel(idx)});
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input logic [3:0] r);
        reset = 1'b1; req = r; lock = 4'b0000; out_ready = 1'b0;
        @(negedge clk);
        chk("grant_in_reset", int'(grant), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
    endtask

    // Monitor: every output handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow actual=%0h/%0h expected=none", out_src, out_data);
            end else begin
                logic [5:0] e;
                e = sb.pop_front();
                if ({out_src, out_data} != e) begin
                    errors++;
                    $display("FAIL out_word actual=src%0d:%0h expected=src%0d:%0h",
                             out_src, out_data, e[5:4], e[3:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; req = '0; lock = '0; out_ready = 1'b0;
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        @(posedge clk); #1;
        do_reset(4'b1111);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_src", int'(out_src), 0);
        req = 4'b0000;
        #1 chk("rst_sel_ptr", int'(sel), 3);

        // Full rotation
        step(4'b1111, 4'b0000, 1'b1, 4'b0001);
        step(4'b1111, 4'b0000, 1'b1, 4'b0010);
        chk("valid_held", int'(out_valid), 1);
        step(4'b1111, 4'b0000, 1'b1, 4'b0100);
        step(4'b1111, 4'b0000, 1'b1, 4'b1000);
        step(4'b1111, 4'b0000, 1'b1, 4'b0001);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000);
        chk("drain1_valid", int'(out_valid), 0);

        // Two requesters alternate
        do_reset(4'b0000);
        d0 = 4'hA; d2 = 4'h5;
        step(4'b0101, 4'b0000, 1'b1, 4'b0001);
        step(4'b0101, 4'b0000, 1'b1, 4'b0100);
        step(4'b0101, 4'b0000, 1'b1, 4'b0001);
        step(4'b0101, 4'b0000, 1'b1, 4'b0100);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000);

        // Backpressure holds the word and blocks grants
        d1 = 4'h6;
        step(4'b0010, 4'b0000, 1'b1, 4'b0010);
        d1 = 4'h7;
        for (int i = 0; i < 3; i++) begin
            step(4'b0010, 4'b0000, 1'b0, 4'b0000);
            chk("stall_data", int'(out_data), 6);
            chk("stall_valid", int'(out_valid), 1);
        end
        step(4'b0010, 4'b0000, 1'b1, 4'b0010);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000);
        chk("bp_valid_fall", int'(out_valid), 0);

        // Lock burst capped at LOCK_MAX beats
        do_reset(4'b0000);
        d0 = 4'h8; d1 = 4'h9;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 4; i++) step(4'b0011, 4'b0001, 1'b1, 4'b0001);
            step(4'b0011, 4'b0001, 1'b1, 4'b0010);
        end
        step(4'b0000, 4'b0000, 1'b1, 4'b0000);

        // Single request then reset during stall
        d3 = 4'hF;
        step(4'b1000, 4'b0000, 1'b0, 4'b1000);
        step(4'b0000, 4'b0000, 1'b0, 4'b0000);
        chk("single_valid", int'(out_valid), 1);
        chk("single_data", int'(out_data), 15);
        chk("single_src", int'(out_src), 3);
        do_reset(4'b1111);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_data", int'(out_data), 0);
        req = 4'b0000;
        #1 chk("mid_rst_ptr", int'(sel), 3);
        d0 = 4'h3;
        step(4'b1111, 4'b0000, 1'b1, 4'b0001);

        // Sparse idle cycles
        for (int i = 0; i < 5; i++) step(4'b0000, 4'b0000, 1'b1, 4'b0000);
        chk("sparse_valid", int'(out_valid), 0);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
